// File: rtl/ex_ma_stage.sv
// EX-side branch resolution, architectural flags register and EX/MA pipeline latch.
// Optional performance counters are built when EX_PERF_CNT_EN is defined.
module ex_ma_stage #(
    parameter int          CTRL_W   = 22,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [31:0]       ex_pc,
    input  logic [31:0]       ex_inst,
    input  logic [CTRL_W-1:0] ex_ctrl,
    input  logic [31:0]       ex_op2,
    input  logic              ex_is_cmp,
    input  logic              ex_is_beq,
    input  logic              ex_is_bgt,
    input  logic              ex_is_ubranch,
    input  logic              ex_is_ret,
    input  logic [31:0]       ex_branch_target,
    input  logic [31:0]       ex_ret_addr,
    input  logic [31:0]       alu_result,
    input  logic              alu_flagsE,
    input  logic              alu_flagsGT,
    output logic              is_branch_taken,
    output logic [31:0]       branch_pc,
    output logic              flags_e,
    output logic              flags_gt,
    output logic              ma_valid,
    output logic [31:0]       ma_pc,
    output logic [31:0]       ma_inst,
    output logic [CTRL_W-1:0] ma_ctrl,
    output logic [31:0]       ma_alu_result,
    output logic [31:0]       ma_op2
`ifdef EX_PERF_CNT_EN
    ,
    output logic [31:0]       perf_taken_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    logic live;

    assign live = ex_valid & ~flush & ~stall;

    // Branch decision uses the registered flags, so a cmp-then-beq pair sees
    // the cmp result one cycle later without any forwarding path.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        is_branch_taken = 1'b0;
        branch_pc       = ex_branch_target;
        if (live) begin
            is_branch_taken = ex_is_ret | ex_is_ubranch
                            | (ex_is_beq & flags_e) | (ex_is_bgt & flags_gt);
            if (ex_is_ret) begin
                branch_pc = ex_ret_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: state registers use non-blocking assignments only.
            flags_e  <= 1'b0;
            flags_gt <= 1'b0;
        end else if (live && ex_is_cmp) begin
            flags_e  <= alu_flagsE;
            flags_gt <= alu_flagsGT;
        end
    end

    // Flush only kills the valid bit; the data fields keep their old contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ma_valid      <= 1'b0;
            ma_pc         <= RESET_PC;
            ma_inst       <= '0;
            ma_ctrl       <= '0;
            ma_alu_result <= '0;
            ma_op2        <= '0;
        end else if (flush) begin
            ma_valid      <= 1'b0;
        end else if (!stall) begin
            ma_valid      <= ex_valid;
            ma_pc         <= ex_pc;
            ma_inst       <= ex_inst;
            ma_ctrl       <= ex_ctrl;
            ma_alu_result <= alu_result;
            ma_op2        <= ex_op2;
        end
    end

`ifdef EX_PERF_CNT_EN
    logic bubble;

    assign bubble = ~stall & (flush | ~ex_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_taken_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (is_branch_taken && perf_taken_cnt != 32'hFFFF_FFFF) begin
                perf_taken_cnt <= perf_taken_cnt + 32'd1;
            end
            if (bubble && perf_bubble_cnt != 32'hFFFF_FFFF) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_ma_stage.sv
// Self-checking bench for ex_ma_stage: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the stage.
module tb_ex_ma_stage;

    localparam int          CTRL_W   = 22;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall, flush, ex_valid;
    logic [31:0]       ex_pc, ex_inst, ex_op2, ex_branch_target, ex_ret_addr, alu_result;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_is_cmp, ex_is_beq, ex_is_bgt, ex_is_ubranch, ex_is_ret;
    logic              alu_flagsE, alu_flagsGT;
    logic              is_branch_taken, flags_e, flags_gt, ma_valid;
    logic [31:0]       branch_pc, ma_pc, ma_inst, ma_alu_result, ma_op2;
    logic [CTRL_W-1:0] ma_ctrl;
`ifdef EX_PERF_CNT_EN
    logic [31:0]       perf_taken_cnt, perf_bubble_cnt;
`endif

    always #5 clk = ~clk;

    ex_ma_stage #(.CTRL_W(CTRL_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_ctrl(ex_ctrl), .ex_op2(ex_op2),
        .ex_is_cmp(ex_is_cmp), .ex_is_beq(ex_is_beq), .ex_is_bgt(ex_is_bgt),
        .ex_is_ubranch(ex_is_ubranch), .ex_is_ret(ex_is_ret),
        .ex_branch_target(ex_branch_target), .ex_ret_addr(ex_ret_addr),
        .alu_result(alu_result), .alu_flagsE(alu_flagsE), .alu_flagsGT(alu_flagsGT),
        .is_branch_taken(is_branch_taken), .branch_pc(branch_pc),
        .flags_e(flags_e), .flags_gt(flags_gt),
        .ma_valid(ma_valid), .ma_pc(ma_pc), .ma_inst(ma_inst), .ma_ctrl(ma_ctrl),
        .ma_alu_result(ma_alu_result), .ma_op2(ma_op2)
`ifdef EX_PERF_CNT_EN
        ,
        .perf_taken_cnt(perf_taken_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic              valid;
        logic [31:0]       pc, inst, alu, op2;
        logic [CTRL_W-1:0] ctrl;
    } ma_rec_t;

    ma_rec_t     m_ma;
    logic        m_fe, m_fgt;
    logic [31:0] m_taken_cnt, m_bubble_cnt;
    bit          chk_en = 1'b0;

    function automatic bit m_live();
        return ex_valid && !flush && !stall;
    endfunction

    function automatic bit m_taken();
        if (!m_live()) return 1'b0;
        if (ex_is_ret || ex_is_ubranch) return 1'b1;
        if (ex_is_beq) return m_fe;
        if (ex_is_bgt) return m_fgt;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_branch_pc();
        return (m_taken() && ex_is_ret) ? ex_ret_addr : ex_branch_target;
    endfunction

    task automatic model_reset();
        m_ma         = '{valid: 1'b0, pc: RESET_PC, inst: 32'h0, alu: 32'h0, op2: 32'h0, ctrl: '0};
        m_fe         = 1'b0;
        m_fgt        = 1'b0;
        m_taken_cnt  = 32'h0;
        m_bubble_cnt = 32'h0;
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            if (m_taken() && m_taken_cnt != 32'hFFFF_FFFF) m_taken_cnt = m_taken_cnt + 1;
            if (!stall && (flush || !ex_valid) && m_bubble_cnt != 32'hFFFF_FFFF)
                m_bubble_cnt = m_bubble_cnt + 1;
            if (m_live() && ex_is_cmp) begin
                m_fe  = alu_flagsE;
                m_fgt = alu_flagsGT;
            end
            if (flush) m_ma.valid = 1'b0;
            else if (!stall)
                m_ma = '{valid: ex_valid, pc: ex_pc, inst: ex_inst, alu: alu_result,
                         op2: ex_op2, ctrl: ex_ctrl};
        end
    end

    // One compare per cycle, half a period after the active edge.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("is_branch_taken", is_branch_taken, m_taken());
            check("branch_pc", branch_pc, m_branch_pc());
            check("flags_e", flags_e, m_fe);
            check("flags_gt", flags_gt, m_fgt);
            check("ma_valid", ma_valid, m_ma.valid);
            if (m_ma.valid) begin
                check("ma_pc", ma_pc, m_ma.pc);
                check("ma_inst", ma_inst, m_ma.inst);
                check("ma_ctrl", ma_ctrl, m_ma.ctrl);
                check("ma_alu_result", ma_alu_result, m_ma.alu);
                check("ma_op2", ma_op2, m_ma.op2);
            end
`ifdef EX_PERF_CNT_EN
            check("perf_taken_cnt", perf_taken_cnt, m_taken_cnt);
            check("perf_bubble_cnt", perf_bubble_cnt, m_bubble_cnt);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        stall = 0; flush = 0; ex_valid = 0;
        ex_pc = 0; ex_inst = 0; ex_ctrl = '0; ex_op2 = 0;
        ex_is_cmp = 0; ex_is_beq = 0; ex_is_bgt = 0; ex_is_ubranch = 0; ex_is_ret = 0;
        ex_branch_target = 0; ex_ret_addr = 0; alu_result = 0;
        alu_flagsE = 0; alu_flagsGT = 0;
    endtask

    task automatic clear_class();
        ex_is_cmp = 0; ex_is_beq = 0; ex_is_bgt = 0; ex_is_ubranch = 0; ex_is_ret = 0;
    endtask

    // Inputs change only at negedge+1, so they are stable across the rising edge.
    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        idle_inputs();
        next();
        next();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        next();
        next();

        check("reset ma_valid", ma_valid, 1'b0);
        check("reset ma_pc", ma_pc, RESET_PC);
        check("reset flags_e", flags_e, 1'b0);
        check("reset flags_gt", flags_gt, 1'b0);
        check("reset ma_alu_result", ma_alu_result, 32'h0);

        // Plain ALU instruction flows to MA after one cycle.
        reset = 1'b0;
        chk_en = 1'b1;
        ex_valid = 1; alu_result = 32'h1234; ex_pc = 32'h40;
        next();
        check("load ma_valid", ma_valid, 1'b1);
        check("load ma_alu_result", ma_alu_result, 32'h1234);
        check("load ma_pc", ma_pc, 32'h40);
        check("load flags_e", flags_e, 1'b0);

        // cmp (E=1, GT=0) then beq taken, then bgt not taken.
        ex_pc = 32'h44; ex_is_cmp = 1; alu_flagsE = 1; alu_flagsGT = 0;
        next();
        check("cmp flags_e", flags_e, 1'b1);
        check("cmp flags_gt", flags_gt, 1'b0);
        clear_class(); ex_pc = 32'h48; ex_is_beq = 1; ex_branch_target = 32'h100;
        #1;
        check("beq taken", is_branch_taken, 1'b1);
        check("beq branch_pc", branch_pc, 32'h100);
        next();
        clear_class(); ex_pc = 32'h88; ex_is_bgt = 1; ex_branch_target = 32'h200;
        #1;
        check("bgt not taken", is_branch_taken, 1'b0);
        next();

        // ret under stall: suppressed and MA holds; released: taken.
        clear_class(); ex_pc = 32'h90; ex_is_ret = 1; ex_ret_addr = 32'h2C; stall = 1;
        #1;
        check("stalled ret", is_branch_taken, 1'b0);
        next();
        check("stall ma_pc hold", ma_pc, 32'h88);
        check("stall ma_valid hold", ma_valid, 1'b1);
        stall = 0;
        #1;
        check("ret taken", is_branch_taken, 1'b1);
        check("ret branch_pc", branch_pc, 32'h2C);
        next();

        // Flushed cmp leaves flags alone and bubbles MA.
        clear_class(); ex_pc = 32'h94; ex_is_cmp = 1; alu_flagsE = 0; alu_flagsGT = 1; flush = 1;
        next();
        check("flushed cmp flags_gt", flags_gt, 1'b0);
        check("flushed cmp flags_e", flags_e, 1'b1);
        check("flush ma_valid", ma_valid, 1'b0);

        // Async reset mid-cycle with MA valid and flags_e set.
        clear_class(); flush = 0; ex_pc = 32'h98;
        next();
        check("pre-reset ma_valid", ma_valid, 1'b1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async ma_valid", ma_valid, 1'b0);
        check("async flags_e", flags_e, 1'b0);
        check("async ma_pc", ma_pc, RESET_PC);
        idle_inputs();
        next();

`ifdef EX_PERF_CNT_EN
        // 3 taken branches, 2 flush cycles, 4 stall cycles.
        check("perf reset taken", perf_taken_cnt, 32'h0);
        check("perf reset bubble", perf_bubble_cnt, 32'h0);
        reset = 1'b0;
        ex_valid = 1; ex_is_ubranch = 1; ex_branch_target = 32'h300;
        repeat (3) next();
        ex_is_ubranch = 0; flush = 1;
        repeat (2) next();
        flush = 0; stall = 1;
        repeat (4) next();
        check("perf taken 3", perf_taken_cnt, 32'd3);
        check("perf bubble 2", perf_bubble_cnt, 32'd2);
        do_reset();
`endif

        // Randomized traffic against the model.
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int cls;
            ex_valid         = ($urandom_range(9) != 0);
            stall            = ($urandom_range(6) == 0);
            flush            = ($urandom_range(7) == 0);
            ex_pc            = $urandom;
            ex_inst          = $urandom;
            ex_ctrl          = CTRL_W'($urandom);
            ex_op2           = $urandom;
            ex_branch_target = $urandom;
            ex_ret_addr      = $urandom;
            alu_result       = $urandom;
            alu_flagsE       = $urandom_range(1);
            alu_flagsGT      = $urandom_range(1);
            clear_class();
            cls = $urandom_range(7);
            case (cls)
                0, 1:    ex_is_cmp     = 1;
                2:       ex_is_beq     = 1;
                3:       ex_is_bgt     = 1;
                4:       ex_is_ubranch = 1;
                5:       ex_is_ret     = 1;
                default: ;
            endcase
            next();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_ma_stage.md
Name: ex_ma_stage

Overview:
- Execute-side consumer of the ALU outputs (aluResult, flagsE, flagsGT).
- Holds the architectural flags register and resolves SimpleRISC branches (b, beq, bgt, call, ret).
- Produces the branch-taken redirect for fetch.
- Latches the EX/MA pipeline register that feeds the memory-access stage.

Parameters:
- CTRL_W, 22, width of the opaque control-signal bundle carried from EX to MA
- RESET_PC, 32'h0, value loaded into ma_pc on reset

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold EX/MA latch and flags (memory or hazard stall)
- flush  input  1  kill the instruction currently in EX; insert bubble into MA
- ex_valid  input  1  EX holds a real instruction
- ex_pc  input  32  PC of the EX instruction
- ex_inst  input  32  instruction word
- ex_ctrl  input  CTRL_W  control bundle, passed through untouched
- ex_op2  input  32  store data / second operand, passed to MA
- ex_is_cmp  input  1  cmp instruction (the ALU's compare select)
- ex_is_beq, ex_is_bgt, ex_is_ubranch, ex_is_ret  input  1 each  branch class; call counts as ubranch
- ex_branch_target  input  32  pc + sign-extended offset, computed upstream
- ex_ret_addr  input  32  ra register value for ret
- alu_result  input  32  ALU result
- alu_flagsE, alu_flagsGT  input  1 each  ALU compare outputs
- is_branch_taken  output  1  redirect fetch this cycle
- branch_pc  output  32  redirect address
- flags_e, flags_gt  output  1 each  architectural flags register
- ma_valid  output  1; ma_pc  output  32; ma_inst  output  32; ma_ctrl  output  CTRL_W; ma_alu_result  output  32; ma_op2  output  32

Behaviour:
- Reset (async, immediate): ma_valid=0, ma_pc=RESET_PC, ma_inst/ma_alu_result/ma_op2=0, ma_ctrl=0, flags_e=0, flags_gt=0. Reset mid-stall or mid-flush wins unconditionally.
- live = ex_valid & ~flush & ~stall.
- Flags register: on the clock edge, if live & ex_is_cmp, flags_e<=alu_flagsE and flags_gt<=alu_flagsGT; otherwise hold. Updated flags become visible the next cycle. A cmp immediately followed by beq is resolved with the new flags; no bypass is needed.
- Branch resolution (combinational from the EX inputs and the registered flags):
  - taken = live & (ex_is_ubranch | ex_is_ret | (ex_is_beq & flags_e) | (ex_is_bgt & flags_gt)).
  - branch_pc = ex_ret_addr when ex_is_ret, else ex_branch_target.
  - When not taken: is_branch_taken=0 and branch_pc=ex_branch_target (don't-care value).
  - More than one class asserted is illegal; priority is ret > ubranch > beq > bgt.
- EX/MA latch priority: reset > flush > stall > load.
  - flush: ma_valid<=0; all other MA fields hold.
  - stall: every MA field and the flags hold.
  - load: ma_valid<=ex_valid; all other fields are copied from the ex_* inputs / alu_result.
  - Latency: 1 cycle EX→MA.
- A flushed or stalled branch never asserts is_branch_taken. A flushed cmp never updates the flags.
- No arithmetic in this block apart from the optional counters; all data paths are 32-bit pass-through.

Optional Feature:
- EX_PERF_CNT_EN.
- When defined, adds two 32-bit outputs, perf_taken_cnt and perf_bubble_cnt, both reset to 0.
  - perf_taken_cnt increments on every cycle with is_branch_taken=1.
  - perf_bubble_cnt increments on every non-stalled edge where ma_valid is loaded with 0 (flush, or ex_valid=0).
  - Both saturate at 32'hFFFF_FFFF; neither counts while stall=1.
- When undefined, neither port nor counter exists and the behaviour above is unchanged.

Test Plan:
- Reset then release, ex_valid=1, alu_result=32'h1234, ex_pc=32'h40 -> one cycle later ma_valid=1, ma_alu_result=32'h1234, ma_pc=32'h40; flags stay 0.
- cmp with alu_flagsE=1, alu_flagsGT=0, then beq next cycle with target 32'h100 -> flags_e=1, is_branch_taken=1, branch_pc=32'h100; a following bgt is not taken.
- ret with ex_ret_addr=32'h2C while stall=1 -> is_branch_taken=0 and MA holds; drop stall -> is_branch_taken=1, branch_pc=32'h2C.
- cmp with flush=1 and alu_flagsGT=1 -> flags_gt stays 0, ma_valid=0 next cycle.
- Assert reset asynchronously mid-cycle with ma_valid=1, flags_e=1 -> outputs clear immediately, before the next clock edge.
- With EX_PERF_CNT_EN: 3 taken branches, 2 flush cycles, 4 stall cycles -> perf_taken_cnt=3, perf_bubble_cnt=2.
